// File: rtl/aes_pkg.sv
// Shared encodings for the iterative AES encrypt sequencer: FSM states,
// datapath phase selects and round-counter sizing.
`timescale 1ns/1ps
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_MID  = 3'd2,
    ST_LAST = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_INIT = 2'd1;
  localparam logic [1:0] SEL_MID  = 2'd2;
  localparam logic [1:0] SEL_LAST = 2'd3;

  localparam int NR_MAX  = 14;
  localparam int ROUND_W = 4;

endpackage

// File: rtl/aes_encrypt_ctrl.sv
// Sequencer for an iterative AES encrypt datapath: owns the 128-bit state,
// the round index and the phase select, with valid/ready on both ends.
`timescale 1ns/1ps
module aes_encrypt_ctrl
  import aes_pkg::*;
#(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] Message,
  output logic [127:0] dp_state,
  output logic [1:0]   dp_sel,
  output logic [3:0]   dp_round,
  input  logic [127:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher,
  output logic         busy
);

  // A key-length/round-count mismatch would walk the wrong key schedule, so
  // such a configuration simply never accepts a message.
  localparam logic CFG_OK = (nr == nk + 6) && (nr <= NR_MAX);
  localparam logic [ROUND_W-1:0] NR_L  = ROUND_W'(nr);
  localparam logic [ROUND_W-1:0] NR_M1 = ROUND_W'(nr - 1);

  state_e               state_q, state_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [127:0]         data_q,  data_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    dp_sel    = SEL_NONE;
    dp_round  = '0;
    cipher    = '0;

    case (state_q)
      ST_IDLE: begin
        in_ready = key_valid & reset & CFG_OK;
        if (in_valid && in_ready) begin
          data_d  = Message;
          round_d = '0;
          state_d = ST_INIT;
        end
      end

      ST_INIT: begin
        busy     = 1'b1;
        dp_sel   = SEL_INIT;
        dp_round = '0;
        if (!key_valid) begin
          state_d = ST_IDLE;
          data_d  = '0;
          round_d = '0;
        end else begin
          data_d  = dp_result;
          round_d = ROUND_W'(1);
          state_d = ST_MID;
        end
      end

      ST_MID: begin
        busy     = 1'b1;
        dp_sel   = SEL_MID;
        dp_round = round_q;
        if (!key_valid) begin
          state_d = ST_IDLE;
          data_d  = '0;
          round_d = '0;
        end else begin
          data_d = dp_result;
          // >= keeps the counter bounded even if it were ever corrupted
          if (round_q >= NR_M1) begin
            round_d = NR_L;
            state_d = ST_LAST;
          end else begin
            round_d = round_q + ROUND_W'(1);
          end
        end
      end

      ST_LAST: begin
        busy     = 1'b1;
        dp_sel   = SEL_LAST;
        dp_round = NR_L;
        if (!key_valid) begin
          state_d = ST_IDLE;
          data_d  = '0;
          round_d = '0;
        end else begin
          data_d  = dp_result;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        cipher    = data_q;
        // Completed block is delivered regardless of key_valid; a new block
        // may be taken on the same edge the cipher is consumed.
        in_ready  = key_valid & out_ready & reset & CFG_OK;
        if (out_ready) begin
          if (in_valid && in_ready) begin
            data_d  = Message;
            round_d = '0;
            state_d = ST_INIT;
          end else begin
            round_d = '0;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        round_d = '0;
        data_d  = '0;
      end
    endcase
  end

  assign dp_state = data_q;

endmodule

// File: tb/tb_aes_encrypt_ctrl.sv
// Bench for aes_encrypt_ctrl: supplies an AES round datapath and key schedule
// around the controller and checks ciphers against a whole-block AES model.
`timescale 1ns/1ps
module tb_aes_encrypt_ctrl;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         key_valid = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] Message = '0;
  logic [127:0] dp_result;
  logic [127:0] dp_state;
  logic [127:0] cipher;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [1:0]   dp_sel;
  logic [3:0]   dp_round;
  logic [127:0] rk [0:15];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_encrypt_ctrl #(.nk(4), .nr(NR)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid),
    .in_valid(in_valid), .in_ready(in_ready), .Message(Message),
    .dp_state(dp_state), .dp_sel(dp_sel), .dp_round(dp_round),
    .dp_result(dp_result), .out_valid(out_valid), .out_ready(out_ready),
    .cipher(cipher), .busy(busy)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, base;
    inv  = 8'h01;
    base = x;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 44; i++) begin
      if (i < 4) begin
        w[i] = key[127-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % 4 == 0) begin
          t = {t[23:0], t[31:24]};
          t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
          rc = xt(rc);
        end
        w[i] = w[i-4] ^ t;
      end
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ round_key(key, 0);
    for (int r = 1; r < NR; r++) s = mix(sub_shift(s)) ^ round_key(key, r);
    return sub_shift(s) ^ round_key(key, NR);
  endfunction

  // Parent-side round logic selected by dp_sel, keyed by dp_round.
  always_comb begin
    dp_result = '0;
    case (dp_sel)
      2'd1:    dp_result = dp_state ^ rk[dp_round];
      2'd2:    dp_result = mix(sub_shift(dp_state)) ^ rk[dp_round];
      2'd3:    dp_result = sub_shift(dp_state) ^ rk[dp_round];
      default: dp_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input logic [127:0] k);
    for (int r = 0; r < 16; r++) rk[r] = (r <= NR) ? round_key(k, r) : '0;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] pt,
                           input int hold, input logic [127:0] exp, input bit chk_seq);
    int n, cnt;
    logic [1:0] sel_q [$];
    logic [3:0] rnd_q [$];
    logic [1:0] exp_sel;
    set_key(key);
    key_valid = 1'b1;
    out_ready = (hold == 0);
    Message   = pt;
    in_valid  = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    chk({tag, "_accept_ready"}, 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 30) begin
      sel_q.push_back(dp_sel);
      rnd_q.push_back(dp_round);
      step();
      cnt++;
    end
    chk({tag, "_latency"}, 128'(cnt), 128'(NR + 1));
    chk({tag, "_cipher"}, cipher, exp);
    if (chk_seq) begin
      for (int i = 0; i <= NR; i++) begin
        exp_sel = (i == 0) ? 2'd1 : ((i == NR) ? 2'd3 : 2'd2);
        chk($sformatf("%s_dp_sel_%0d", tag, i), (i < sel_q.size()) ? 128'(sel_q[i]) : 128'hx, 128'(exp_sel));
        chk($sformatf("%s_dp_round_%0d", tag, i), (i < rnd_q.size()) ? 128'(rnd_q[i]) : 128'hx, 128'(i));
      end
    end
    if (hold > 0) begin
      Message  = rand128();
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        step();
        chk({tag, "_hold_valid"}, 128'(out_valid), 128'd1);
        chk({tag, "_hold_cipher"}, cipher, exp);
        chk({tag, "_hold_in_ready"}, 128'(in_ready), 128'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    step();
    chk({tag, "_drained"}, 128'(out_valid), 128'd0);
    chk({tag, "_idle_busy"}, 128'(busy), 128'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] k, a, b, snap;
    int n, cnt, seen;

    // Reset state: outputs held at zero even with key_valid asserted.
    key_valid = 1'b1;
    set_key('0);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_dp_state", dp_state, 128'd0);
    chk("rst_dp_sel", 128'(dp_sel), 128'd0);
    chk("rst_cipher", cipher, 128'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    step();
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);

    // Known-answer vector, sink always ready.
    run_block("kat1", 128'h5468617473206D79204B756E67204675,
              128'h54776F204F6E65204E696E652054776F, 0,
              128'h29C3505F571420F6402299B31A02D73A, 1'b1);

    // FIPS-197 C.1 with back-pressure on the output.
    run_block("fips", 128'h000102030405060708090a0b0c0d0e0f,
              128'h00112233445566778899aabbccddeeff, 5,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);

    // Asynchronous reset while the last round is in flight.
    k = rand128();
    set_key(k);
    key_valid = 1'b1;
    out_ready = 1'b0;
    Message   = rand128();
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (dp_sel != 2'd3 && n < 30) begin step(); n++; end
    chk("arst_reached_last", 128'(dp_sel), 128'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_in_ready", 128'(in_ready), 128'd0);
    chk("arst_out_valid", 128'(out_valid), 128'd0);
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_dp_sel", 128'(dp_sel), 128'd0);
    chk("arst_dp_round", 128'(dp_round), 128'd0);
    chk("arst_cipher", cipher, 128'd0);
    chk("arst_dp_state", dp_state, 128'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    step();
    chk("arst_release_busy", 128'(busy), 128'd0);
    chk("arst_release_ready", 128'(in_ready), 128'd1);

    // Back-to-back blocks: second accepted on the DONE edge.
    k = rand128();
    a = rand128();
    b = rand128();
    set_key(k);
    key_valid = 1'b1;
    out_ready = 1'b1;
    Message   = a;
    in_valid  = 1'b1;
    #1;
    chk("b2b_ready_a", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    Message = b;
    cnt = 0;
    while (!out_valid && cnt < 30) begin step(); cnt++; end
    chk("b2b_latency_a", 128'(cnt), 128'(NR + 1));
    chk("b2b_cipher_a", cipher, aes_ref(k, a));
    chk("b2b_ready_done", 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    chk("b2b_init_b", 128'(dp_sel), 128'd1);
    cnt = 1;
    while (!out_valid && cnt < 40) begin step(); cnt++; end
    chk("b2b_spacing", 128'(cnt), 128'(NR + 2));
    chk("b2b_cipher_b", cipher, aes_ref(k, b));
    step();
    chk("b2b_drained", 128'(out_valid), 128'd0);
    out_ready = 1'b0;

    // key_valid drop during MID round 4 aborts the block.
    k = rand128();
    set_key(k);
    key_valid = 1'b1;
    Message   = rand128();
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!(dp_sel == 2'd2 && dp_round == 4'd4) && n < 30) begin step(); n++; end
    chk("abort_reached_r4", 128'(dp_round), 128'd4);
    key_valid = 1'b0;
    step();
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_dp_sel", 128'(dp_sel), 128'd0);
    chk("abort_dp_state", dp_state, 128'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen++;
      step();
    end
    chk("abort_no_out_valid", 128'(seen), 128'd0);
    a = rand128();
    run_block("resend", k, a, 0, aes_ref(k, a), 1'b0);

    // in_valid with key_valid low must be ignored.
    key_valid = 1'b0;
    Message   = rand128();
    in_valid  = 1'b1;
    snap      = dp_state;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("nokey_in_ready", 128'(in_ready), 128'd0);
      step();
      chk("nokey_busy", 128'(busy), 128'd0);
    end
    chk("nokey_state", dp_state, snap);
    in_valid = 1'b0;

    // Randomized blocks with random output back-pressure.
    for (int t = 0; t < 6; t++) begin
      k = rand128();
      a = rand128();
      run_block($sformatf("rnd%0d", t), k, a, int'($urandom_range(0, 3)), aes_ref(k, a), t == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
